priority_resolver: RTL and testbench

Interrupt priority resolver and in-service logic of an 8259A-compatible PIC. It samples IR0–IR7 into the IRR, applies the IMR, and resolves the highest-priority request under fixed or rotating priority. It raises INT, services the two-pulse INTA acknowledge sequence, and maintains the ISR. OCW2-style commands on `operation` select the priority mode and the end-of-interrupt handling.

---
 rtl/pic_pkg.sv | 33 +++
 rtl/pic_rotating_encoder.sv | 31 +++
 rtl/priority_resolver.sv | 229 ++++++++++++++++++++++
 tb/tb_priority_resolver.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A-style priority resolver: OCW2 field
// positions, command codes, acknowledge FSM states and a priority-rank helper.
package pic_pkg;

  // OCW2 field positions
  localparam int OP_R_BIT   = 7;
  localparam int OP_SL_BIT  = 6;
  localparam int OP_EOI_BIT = 5;
  localparam int OP_LVL_MSB = 2;
  localparam int OP_LVL_LSB = 0;

  // Command codes formed from {R, SL, EOI}
  localparam logic [2:0] CMD_NOP       = 3'b000;
  localparam logic [2:0] CMD_NSEOI     = 3'b001;
  localparam logic [2:0] CMD_FIXED     = 3'b010;
  localparam logic [2:0] CMD_SEOI      = 3'b011;
  localparam logic [2:0] CMD_SET_AROT  = 3'b100;
  localparam logic [2:0] CMD_ROT_NSEOI = 3'b101;
  localparam logic [2:0] CMD_SET_PRI   = 3'b110;
  localparam logic [2:0] CMD_ROT_SEOI  = 3'b111;

  // Two-pulse INTA acknowledge tracking
  typedef enum logic {
    WAIT_FIRST  = 1'b0,
    WAIT_SECOND = 1'b1
  } ack_state_e;

  // Rank of a level under the current bottom: 0 is highest priority, 7 lowest.
  function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] bottom);
    return lvl - bottom - 3'd1;
  endfunction

endpackage

// File: rtl/pic_rotating_encoder.sv
// Rotating priority encoder: finds the highest-priority set bit of req_i when
// level (bottom_i+1) mod 8 is highest and bottom_i is lowest.
module pic_rotating_encoder
  import pic_pkg::*;
(
  input  logic [7:0] req_i,
  input  logic [2:0] bottom_i,
  output logic       valid_o,
  output logic [2:0] idx_o
);

  logic       valid_s;
  logic [2:0] idx_s;
  logic [2:0] lvl_s;

  // Walk levels from highest to lowest priority and keep the first one set.
  always_comb begin
    valid_s = 1'b0;
    idx_s   = 3'd0;
    lvl_s   = 3'd0;
    for (int j = 0; j < 8; j++) begin
      lvl_s   = bottom_i + 3'd1 + 3'(j);
      idx_s   = (req_i[lvl_s] && !valid_s) ? lvl_s : idx_s;
      valid_s = valid_s | req_i[lvl_s];
    end
  end

  assign valid_o = valid_s;
  assign idx_o   = idx_s;

endmodule

// File: rtl/priority_resolver.sv
// 8259A-style interrupt priority resolver: IRR/IMR/ISR, fixed or rotating
// priority, fully nested INT generation, two-pulse INTA and OCW2 commands.
module priority_resolver
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic [7:0] IM,
  input  logic [7:0] operation,
  input  logic       INTA,
  input  logic       AEOI,
  input  logic       LTIM,
  output logic       INT,
  output logic [2:0] INT_VEC,
  output logic [7:0] ISR,
  output logic [7:0] IRR,
  output logic [7:0] IMR
);

  ack_state_e state_q, state_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] imr_q;
  logic       int_q, int_d;
  logic [2:0] vec_q, vec_d;
  logic [2:0] bottom_q, bottom_d;
  logic       arot_q, arot_d;
  logic [7:0] op_q;
  logic [7:0] ir_prev_q;
  logic       inta_sync1_q, inta_sync2_q, inta_prev_q;

  logic       ack_s, first_ack_s, second_ack_s;
  logic       op_fire_s;
  logic [2:0] cmd_s, op_lvl_s;
  logic       cand_valid_s, top_valid_s, eoi_valid_s;
  logic [2:0] cand_idx_s, top_idx_s, eoi_idx_s;
  logic       int_req_s;
  logic [7:0] isr_ack_s;
  logic [7:0] irr_clr_s;

  // Acknowledge event is the falling edge of the synchronised INTA.
  assign ack_s        = inta_prev_q & ~inta_sync2_q;
  assign first_ack_s  = ack_s && (state_q == WAIT_FIRST);
  assign second_ack_s = ack_s && (state_q == WAIT_SECOND);

  // A command runs once, in the cycle its value first differs from last cycle.
  assign op_fire_s = (operation != op_q);
  assign cmd_s     = {operation[OP_R_BIT], operation[OP_SL_BIT], operation[OP_EOI_BIT]};
  assign op_lvl_s  = operation[OP_LVL_MSB:OP_LVL_LSB];

  // Highest-priority unmasked request
  pic_rotating_encoder u_cand (
    .req_i    (irr_q & ~imr_q),
    .bottom_i (bottom_q),
    .valid_o  (cand_valid_s),
    .idx_o    (cand_idx_s)
  );

  // Highest-priority in-service level, used for nesting
  pic_rotating_encoder u_isr_top (
    .req_i    (isr_q),
    .bottom_i (bottom_q),
    .valid_o  (top_valid_s),
    .idx_o    (top_idx_s)
  );

  // Highest-priority in-service level after this cycle's INTA update, for EOI
  pic_rotating_encoder u_eoi (
    .req_i    (isr_ack_s),
    .bottom_i (bottom_q),
    .valid_o  (eoi_valid_s),
    .idx_o    (eoi_idx_s)
  );

  assign int_req_s = cand_valid_s &&
                     (!top_valid_s ||
                      (prio_rank(cand_idx_s, bottom_q) < prio_rank(top_idx_s, bottom_q)));

  // ISR after the INTA effects, before any command clear is applied.
  always_comb begin
    isr_ack_s = isr_q;
    if (first_ack_s && cand_valid_s) begin
      isr_ack_s[cand_idx_s] = 1'b1;
    end else if (second_ack_s && AEOI) begin
      isr_ack_s[vec_q] = 1'b0;
    end else begin
      isr_ack_s = isr_q;
    end
  end

  // Acknowledge FSM, IRR update and OCW2 command execution.
  always_comb begin
    state_d   = state_q;
    isr_d     = isr_ack_s;
    irr_d     = irr_q;
    vec_d     = vec_q;
    bottom_d  = bottom_q;
    arot_d    = arot_q;
    int_d     = 1'b0;
    irr_clr_s = 8'h00;

    case (state_q)
      WAIT_FIRST: begin
        if (ack_s) begin
          state_d = WAIT_SECOND;
          if (cand_valid_s) begin
            vec_d                 = cand_idx_s;
            irr_clr_s[cand_idx_s] = 1'b1;
          end else begin
            vec_d = vec_q;
          end
        end else begin
          int_d = int_req_s;
        end
      end
      WAIT_SECOND: begin
        if (ack_s) begin
          state_d = WAIT_FIRST;
          if (AEOI && arot_q) begin
            bottom_d = vec_q;
          end else begin
            bottom_d = bottom_q;
          end
        end else begin
          state_d = WAIT_SECOND;
        end
      end
      default: begin
        state_d = WAIT_FIRST;
      end
    endcase

    if (LTIM) begin
      irr_d = IR;
    end else begin
      irr_d = (irr_q & ~irr_clr_s) | (IR & ~ir_prev_q);
    end

    if (op_fire_s) begin
      case (cmd_s)
        CMD_NOP: begin
          isr_d = isr_ack_s;
        end
        CMD_NSEOI: begin
          if (eoi_valid_s) begin
            isr_d[eoi_idx_s] = 1'b0;
          end else begin
            isr_d = isr_ack_s;
          end
        end
        CMD_FIXED: begin
          bottom_d = 3'd7;
          arot_d   = 1'b0;
        end
        CMD_SEOI: begin
          isr_d[op_lvl_s] = 1'b0;
        end
        CMD_SET_AROT: begin
          arot_d = 1'b1;
        end
        CMD_ROT_NSEOI: begin
          if (eoi_valid_s) begin
            isr_d[eoi_idx_s] = 1'b0;
            bottom_d         = eoi_idx_s;
          end else begin
            isr_d = isr_ack_s;
          end
        end
        CMD_SET_PRI: begin
          bottom_d = op_lvl_s;
        end
        CMD_ROT_SEOI: begin
          if (eoi_valid_s) begin
            isr_d[op_lvl_s] = 1'b0;
            bottom_d        = op_lvl_s;
          end else begin
            isr_d = isr_ack_s;
          end
        end
        default: begin
          isr_d = isr_ack_s;
        end
      endcase
    end else begin
      isr_d = isr_ack_s;
    end
  end

  // State registers; reset restores fixed priority with IR0 highest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_FIRST;
      isr_q        <= 8'h00;
      irr_q        <= 8'h00;
      imr_q        <= 8'h00;
      int_q        <= 1'b0;
      vec_q        <= 3'd0;
      bottom_q     <= 3'd7;
      arot_q       <= 1'b0;
      op_q         <= 8'h00;
      ir_prev_q    <= 8'h00;
      inta_sync1_q <= 1'b0;
      inta_sync2_q <= 1'b0;
      inta_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      isr_q        <= isr_d;
      irr_q        <= irr_d;
      imr_q        <= IM;
      int_q        <= int_d;
      vec_q        <= vec_d;
      bottom_q     <= bottom_d;
      arot_q       <= arot_d;
      op_q         <= operation;
      ir_prev_q    <= IR;
      inta_sync1_q <= INTA;
      inta_sync2_q <= inta_sync1_q;
      inta_prev_q  <= inta_sync2_q;
    end
  end

  assign INT     = int_q;
  assign INT_VEC = vec_q;
  assign ISR     = isr_q;
  assign IRR     = irr_q;
  assign IMR     = imr_q;

endmodule

// File: tb/tb_priority_resolver.sv
// Directed testbench for priority_resolver: stimulus pushes hand-computed
// expectations into a scoreboard queue, a monitor pops and compares them.
module tb_priority_resolver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] IR, IM, operation;
  logic       INTA, AEOI, LTIM;
  logic       INT;
  logic [2:0] INT_VEC;
  logic [7:0] ISR, IRR, IMR;

  localparam int S_INT = 0;
  localparam int S_VEC = 1;
  localparam int S_ISR = 2;
  localparam int S_IRR = 3;
  localparam int S_IMR = 4;

  typedef struct {
    string      name;
    int         sig;
    logic [7:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic sample = 1'b0;

  always #5 clk = ~clk;

  priority_resolver dut (
    .clk       (clk),
    .reset     (reset),
    .IR        (IR),
    .IM        (IM),
    .operation (operation),
    .INTA      (INTA),
    .AEOI      (AEOI),
    .LTIM      (LTIM),
    .INT       (INT),
    .INT_VEC   (INT_VEC),
    .ISR       (ISR),
    .IRR       (IRR),
    .IMR       (IMR)
  );

  function automatic logic [7:0] dut_val(input int sig);
    case (sig)
      S_INT:   return {7'd0, INT};
      S_VEC:   return {5'd0, INT_VEC};
      S_ISR:   return ISR;
      S_IRR:   return IRR;
      default: return IMR;
    endcase
  endfunction

  // Monitor: on a sample strobe, pop every queued expectation and compare.
  always @(negedge clk) begin
    if (sample) begin
      while (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        n_vec++;
        if (dut_val(e.sig) !== e.val) begin
          n_bad++;
          $display("FAIL %s: got %02h, expected %02h", e.name, dut_val(e.sig), e.val);
        end
      end
    end
  end

  task automatic want(input string name, input int sig, input logic [7:0] val);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic check();
    sample = 1'b1;
    @(negedge clk);
    #1;
    sample = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic inta_one();
    INTA = 1'b1;
    tick(2);
    INTA = 1'b0;
    tick(5);
  endtask

  task automatic inta_both();
    inta_one();
    inta_one();
  endtask

  task automatic set_op(input logic [7:0] v);
    operation = v;
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; IR = 8'h00; IM = 8'h00; operation = 8'h00;
    INTA = 1'b0; AEOI = 1'b0; LTIM = 1'b1;
    tick(2);
    n_vec++;
    if (ISR !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_isr_now: got %02h, expected 00", ISR);
    end
    n_vec++;
    if (IMR !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_imr_now: got %02h, expected 00", IMR);
    end
    want("rst_int", S_INT, 8'h00); want("rst_vec", S_VEC, 8'h00);
    want("rst_isr", S_ISR, 8'h00); want("rst_irr", S_IRR, 8'h00);
    want("rst_imr", S_IMR, 8'h00);
    check();
    reset = 1'b0;
    tick(2);

    // Auto-rotate with automatic EOI, level triggered
    AEOI = 1'b1;
    set_op(8'h80);
    IR = 8'h48;
    tick(3);
    want("ar_irr", S_IRR, 8'h48); want("ar_int", S_INT, 8'h01);
    check();
    inta_one();
    want("ar_isr1", S_ISR, 8'h08); want("ar_vec1", S_VEC, 8'h03); want("ar_int_low", S_INT, 8'h00);
    check();
    inta_one();
    want("ar_isr2", S_ISR, 8'h00); want("ar_vec_hold", S_VEC, 8'h03); want("ar_int_again", S_INT, 8'h01);
    check();
    IR = 8'h49;
    tick(3);
    inta_one(); want("ar_rot6", S_VEC, 8'h06); want("ar_rot6_isr", S_ISR, 8'h40); check();
    inta_one();
    inta_one(); want("ar_rot0", S_VEC, 8'h00); want("ar_rot0_isr", S_ISR, 8'h01); check();
    inta_one();
    inta_one(); want("ar_rot3", S_VEC, 8'h03); want("ar_rot3_isr", S_ISR, 8'h08); check();
    inta_one();
    want("ar_end_isr", S_ISR, 8'h00); check();

    // Fixed priority with non-specific EOI
    AEOI = 1'b0;
    IR = 8'h81;
    set_op(8'h40);
    tick(2);
    want("fx_int", S_INT, 8'h01); check();
    inta_both();
    want("fx_vec0", S_VEC, 8'h00); want("fx_isr0", S_ISR, 8'h01); want("fx_nest_int", S_INT, 8'h00);
    check();
    set_op(8'h20);
    want("fx_eoi", S_ISR, 8'h00); check();
    IR = 8'h84;
    tick(3);
    inta_both();
    want("fx_vec2", S_VEC, 8'h02); want("fx_isr2", S_ISR, 8'h04); check();
    IR = 8'h80;
    tick(3);
    want("fx_blocked", S_INT, 8'h00); check();
    set_op(8'h00);
    set_op(8'h20);
    want("fx_eoi2", S_ISR, 8'h00); want("fx_int7", S_INT, 8'h01); check();
    inta_both();
    want("fx_vec7", S_VEC, 8'h07); want("fx_isr7", S_ISR, 8'h80); check();
    set_op(8'h00);
    set_op(8'h20);
    want("fx_eoi3", S_ISR, 8'h00); check();

    // Set priority (bottom=3) and specific EOI, edge triggered
    IR = 8'h00;
    tick(2);
    LTIM = 1'b0;
    set_op(8'hC3);
    IR = 8'h31;
    tick(3);
    want("sp_irr", S_IRR, 8'h31); want("sp_int", S_INT, 8'h01); check();
    inta_both();
    want("sp_vec4", S_VEC, 8'h04); want("sp_isr4", S_ISR, 8'h10); want("sp_irr4", S_IRR, 8'h21);
    want("sp_nest", S_INT, 8'h00);
    check();
    set_op(8'h20);
    want("sp_eoi4", S_ISR, 8'h00); check();
    inta_both();
    want("sp_vec5", S_VEC, 8'h05); want("sp_isr5", S_ISR, 8'h20); check();
    set_op(8'h00);
    set_op(8'h20);
    inta_both();
    want("sp_vec0", S_VEC, 8'h00); want("sp_isr0", S_ISR, 8'h01); want("sp_irr0", S_IRR, 8'h00);
    check();
    set_op(8'h60);
    want("sp_seoi", S_ISR, 8'h00); check();
    set_op(8'h60);
    want("sp_held_op", S_ISR, 8'h00); check();

    // Masking, level triggered
    IR = 8'h00;
    LTIM = 1'b1;
    IM = 8'h01;
    IR = 8'h01;
    tick(3);
    want("mk_int", S_INT, 8'h00); want("mk_imr", S_IMR, 8'h01); want("mk_irr", S_IRR, 8'h01);
    check();
    IR = 8'h03;
    tick(3);
    want("mk_int1", S_INT, 8'h01); check();
    inta_both();
    want("mk_vec1", S_VEC, 8'h01); want("mk_isr1", S_ISR, 8'h02); check();
    IR = 8'h00;
    set_op(8'h00);
    set_op(8'h20);
    IM = 8'h00;
    tick(2);
    want("mk_clean", S_ISR, 8'h00); check();

    // Edge trigger with AEOI, then nesting
    LTIM = 1'b0;
    AEOI = 1'b1;
    tick(2);
    IR = 8'h01;
    tick(3);
    want("ed_irr", S_IRR, 8'h01); want("ed_int", S_INT, 8'h01); check();
    inta_one();
    want("ed_irr_clr", S_IRR, 8'h00); want("ed_isr", S_ISR, 8'h01); want("ed_vec", S_VEC, 8'h00);
    check();
    inta_one();
    want("ed_aeoi", S_ISR, 8'h00); check();
    tick(3);
    want("ed_hold_irr", S_IRR, 8'h00); want("ed_hold_int", S_INT, 8'h00); check();
    AEOI = 1'b0;
    IR = 8'h11;
    tick(3);
    want("nz_irr", S_IRR, 8'h10); check();
    inta_both();
    want("nz_vec4", S_VEC, 8'h04); want("nz_isr4", S_ISR, 8'h10); check();
    IR = 8'h15;
    tick(3);
    want("nz_irr2", S_IRR, 8'h04); want("nz_blocked", S_INT, 8'h00); check();

    // Async reset in the middle of an acknowledge sequence
    IM = 8'h80;
    tick(2);
    inta_one();
    want("rs_pre_isr", S_ISR, 8'h14); want("rs_pre_vec", S_VEC, 8'h02); check();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_vec++;
    if (INT !== 1'b0) begin
      n_bad++;
      $display("FAIL rs_int_now: got %0b, expected 0", INT);
    end
    n_vec++;
    if (IRR !== 8'h00) begin
      n_bad++;
      $display("FAIL rs_irr_now: got %02h, expected 00", IRR);
    end
    want("rs_int", S_INT, 8'h00); want("rs_isr", S_ISR, 8'h00); want("rs_irr", S_IRR, 8'h00);
    want("rs_imr", S_IMR, 8'h00); want("rs_vec", S_VEC, 8'h00);
    check();
    IM = 8'h00; LTIM = 1'b1; IR = 8'h81; operation = 8'h00;
    tick(2);
    reset = 1'b0;
    tick(3);
    want("rs_post_int", S_INT, 8'h01); want("rs_post_irr", S_IRR, 8'h81); check();
    inta_both();
    want("rs_bottom7", S_VEC, 8'h00); want("rs_fsm_isr", S_ISR, 8'h01); check();

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    if (n_bad != 0) begin
      $display("FAIL: %0d miscompares", n_bad);
    end else begin
      $display("PASS");
    end
    $finish;
  end

endmodule
